muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, sets operand width; HI and LO are WIDTH bits each.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request valid this cycle.
REQ-005 op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-006 a  input  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO source).
REQ-007 b  input  WIDTH  operand B (divisor / multiplier).
REQ-008 flush  input  1  cancel in-flight operation and block acceptance this cycle.
REQ-009 stall  output  1  pipeline hold request while a divide is in progress.
REQ-010 valid  output  1  one-cycle pulse: HI/LO updated by a completed MULT/MULTU/DIV/DIVU.
REQ-011 hi  output  WIDTH  HI register, held between writes.
REQ-012 lo  output  WIDTH  LO register, held between writes.

Function
REQ-013 FSM states IDLE, DIV, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-014 Acceptance: start=1, flush=0, op not reserved, state IDLE or DONE; otherwise ignored (start in DIV dropped, no queueing).
REQ-015 MULT/MULTU: on accept, {hi,lo} <= 2*WIDTH-bit product (signed/unsigned), state -> DONE; valid=1 the following cycle.
REQ-016 DIV/DIVU: on accept, latch operand magnitudes and signs, load counter WIDTH-1, state -> DIV; one restoring quotient bit per cycle; at counter 0, hi/lo written and state -> DONE; valid=1 WIDTH+1 cycles after the accept cycle.
REQ-017 Result mapping: lo = quotient, hi = remainder; signed quotient sign = sign(a) XOR sign(b), remainder sign = sign(a).
REQ-018 Divide by zero (b=0, either signedness): no trap; lo = all ones, hi = a; same latency as normal divide.
REQ-019 Signed overflow (a = -2^(WIDTH-1), b = -1): lo = -2^(WIDTH-1), hi = 0.
REQ-020 MTHI/MTLO: on accept, hi (resp. lo) <= a next edge, other register unchanged, state stays/returns IDLE, valid stays 0.
REQ-021 stall = (state==DIV) OR (accept of DIV/DIVU this cycle, combinational); stall=0 in DONE and IDLE otherwise.
REQ-022 flush in DIV: abort next edge to IDLE, hi/lo unchanged, no valid; flush in DONE does not retract valid (result already committed).
REQ-023 Simultaneous flush and start: flush wins, request not accepted, stall=0.
REQ-024 Back-to-back: start accepted in DONE begins new operation that same edge; valid of the prior op still asserted that cycle.

Reset
REQ-025 rst=1: state IDLE, counter 0, hi=0, lo=0, valid=0, stall=0; rst dominates start and flush.
REQ-026 rst mid-divide aborts operation; no valid pulse afterwards.

Structure
REQ-027 Package muldiv_pkg holds op encoding constants and the FSM state typedef; shared with decoder and hazard unit.
REQ-028 Iterative divider datapath (partial remainder, quotient shift, counter) is sub-module muldiv_div_core; sign fix-up and HI/LO registers stay in muldiv_unit.
REQ-029 Multiply is a single combinational WIDTH x WIDTH product registered into HI/LO; no multi-cycle multiplier.

Verification
REQ-030 WIDTH=32, MULT a=0xFFFFFFFE(-2), b=3 -> next cycle valid=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-031 DIV a=-7, b=2 -> stall=1 for cycles 0..32, valid=1 at cycle 33, lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
REQ-032 DIVU a=100, b=0 -> valid at cycle 33, lo=0xFFFFFFFF, hi=100; DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-033 DIVU started, flush at cycle 10 -> cycle 11 IDLE, stall=0, valid never pulses, hi/lo keep previous values; start+flush same cycle -> no accept.
REQ-034 MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 -> hi/lo match, valid=0; rst asserted mid-DIV -> hi=lo=0, stall=0, no valid.
REQ-035 WIDTH=8 regression: DIVU 200/7 -> valid at cycle 9, lo=28, hi=4.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM state type and op-class helpers for the mul/div unit
package muldiv_pkg;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, DIV, DONE} stateT;

    function automatic logic isDivOp(input logic [2:0] op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction

    function automatic logic isReservedOp(input logic [2:0] op);
        return op[2] && op[1];
    endfunction
endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: unsigned restoring divider, one quotient bit per step
module muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotNext,
    output logic [WIDTH-1:0] remNext,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] quot, rem, dvsr;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   shifted;
    logic             fits;
    // next partial remainder and quotient for the current step
    always_comb begin
        shifted  = {rem, quot[WIDTH-1]};
        fits     = shifted >= {1'b0, dvsr};
        remNext  = fits ? WIDTH'(shifted - {1'b0, dvsr}) : shifted[WIDTH-1:0];
        quotNext = {quot[WIDTH-2:0], fits};
        last     = count == '0;
    end
    // load operands on accept, then shift one bit per step
    always_ff @(posedge clk) begin
        if (rst) begin
            quot  <= '0;
            rem   <= '0;
            dvsr  <= '0;
            count <= '0;
        end else if (load) begin
            quot  <= dividend;
            rem   <= '0;
            dvsr  <= divisor;
            count <= CW'(WIDTH - 1);
        end else if (step) begin
            quot  <= quotNext;
            rem   <= remNext;
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply-divide unit with single-cycle multiply and iterative divide
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    stateT state, stateNext;
    logic accept, divAccept, divFinish, divLast, aNeg, bNeg, qNeg, rNeg, bZero;
    logic [WIDTH-1:0]   aMag, bMag, aHold, quotNext, remNext, quotFix, remFix;
    logic [2*WIDTH-1:0] prodS, prodU;
    // acceptance, handshake outputs, operand prep, sign fix-up and next state
    always_comb begin
        accept    = !rst && start && !flush && !isReservedOp(op) && state != DIV;
        divAccept = accept && isDivOp(op);
        stall     = !rst && (state == DIV || divAccept);
        valid     = !rst && state == DONE;
        divFinish = state == DIV && !flush && divLast;
        aNeg      = op == OP_DIV && a[WIDTH-1];
        bNeg      = op == OP_DIV && b[WIDTH-1];
        aMag      = aNeg ? -a : a;
        bMag      = bNeg ? -b : b;
        prodS     = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prodU     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        quotFix   = bZero ? '1 : (qNeg ? -quotNext : quotNext);
        remFix    = bZero ? aHold : (rNeg ? -remNext : remNext);
        stateNext = state == DONE ? IDLE : state;
        if (state == DIV && (flush || divLast)) stateNext = flush ? IDLE : DONE;
        if (accept) stateNext = isDivOp(op) ? DIV : (op[2] ? IDLE : DONE);
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= stateNext;
    end
    // result sign and divide-by-zero info captured at divide accept
    always_ff @(posedge clk) begin
        if (rst) begin
            qNeg  <= 1'b0;
            rNeg  <= 1'b0;
            bZero <= 1'b0;
            aHold <= '0;
        end else if (divAccept) begin
            qNeg  <= aNeg ^ bNeg;
            rNeg  <= aNeg;
            bZero <= b == '0;
            aHold <= a;
        end
    end
    // HI/LO architectural registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (divFinish) begin
            hi <= remFix;
            lo <= quotFix;
        end else if (accept && !op[2] && !op[1]) begin
            {hi, lo} <= op[0] ? prodU : prodS;
        end else if (accept && op == OP_MTHI) begin
            hi <= a;
        end else if (accept && op == OP_MTLO) begin
            lo <= a;
        end
    end

    muldiv_div_core #(.WIDTH(WIDTH)) divCore (
        .clk      (clk),
        .rst      (rst),
        .load     (divAccept),
        .step     (state == DIV),
        .dividend (aMag),
        .divisor  (bMag),
        .quotNext (quotNext),
        .remNext  (remNext),
        .last     (divLast)
    );
endmodule
